query_dispatcher: RTL

- Sits between the PCIe stream input handler and a bank of NUM_ENGINES Smith-Waterman engines.
- Each query (one info beat plus N sequence-block beats) goes to a single idle engine, selected round-robin.
- All blocks of a query are steered to the engine that accepted its info beat.
- Tracks per-engine busy status from engine done pulses and counts dispatched queries.

---
 rtl/query_dispatcher.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/query_dispatcher.sv
// Query dispatcher: steers each query (info beat plus N block beats) to one idle
// Smith-Waterman engine chosen round-robin, and tracks engine busy state.
module query_dispatcher #(
   parameter int NUM_ENGINES = 4,
   parameter int ENG_IDX_W   = 2,
   parameter int NUM_PES     = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [24:0]              ref_length_in,
   input  logic [24:0]              ref_addr_in,
   input  logic [15:0]              num_query_blocks_in,
   input  logic [15:0]              query_id_in,
   input  logic [31:0]              cell_score_threshold_in,
   input  logic                     query_info_valid_in,
   output logic                     query_info_rdy_out,
   input  logic [NUM_PES*2-1:0]     query_seq_block_in,
   input  logic                     query_seq_block_valid_in,
   output logic                     query_seq_block_rdy_out,
   output logic [24:0]              eng_ref_length_out,
   output logic [24:0]              eng_ref_addr_out,
   output logic [15:0]              eng_num_query_blocks_out,
   output logic [15:0]              eng_query_id_out,
   output logic [31:0]              eng_cell_score_threshold_out,
   output logic [NUM_PES*2-1:0]     eng_query_seq_block_out,
   output logic [NUM_ENGINES-1:0]   eng_query_info_valid_out,
   input  logic [NUM_ENGINES-1:0]   eng_query_info_rdy_in,
   output logic [NUM_ENGINES-1:0]   eng_query_seq_block_valid_out,
   input  logic [NUM_ENGINES-1:0]   eng_query_seq_block_rdy_in,
   input  logic [NUM_ENGINES-1:0]   eng_done_in,
   output logic [NUM_ENGINES-1:0]   eng_busy_out,
   output logic [ENG_IDX_W-1:0]     sel_engine_out,
   output logic [31:0]              dispatch_cnt_out
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_INFO   = 2'd1,
      ST_BLOCKS = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ENG_IDX_W-1:0]   sel_q, sel_d;
   logic [ENG_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]            num_blocks_q, num_blocks_d;
   logic [15:0]            block_cnt_q, block_cnt_d;
   logic [NUM_ENGINES-1:0] busy_q, busy_d;
   logic [31:0]            dispatch_cnt_q, dispatch_cnt_d;

   logic [NUM_ENGINES-1:0] sel_onehot_s;
   logic [ENG_IDX_W:0]     cand_s;
   logic [ENG_IDX_W-1:0]   free_idx_s;
   logic                   all_busy_s;
   logic                   info_xfer_s;
   logic                   blk_xfer_s;

   assign eng_ref_length_out           = ref_length_in;
   assign eng_ref_addr_out             = ref_addr_in;
   assign eng_num_query_blocks_out     = num_query_blocks_in;
   assign eng_query_id_out             = query_id_in;
   assign eng_cell_score_threshold_out = cell_score_threshold_in;
   assign eng_query_seq_block_out      = query_seq_block_in;

   assign eng_busy_out     = busy_q;
   assign sel_engine_out   = sel_q;
   assign dispatch_cnt_out = dispatch_cnt_q;

   assign sel_onehot_s = NUM_ENGINES'(1) << sel_q;
   assign all_busy_s   = &busy_q;
   assign info_xfer_s  = query_info_valid_in && query_info_rdy_out;
   assign blk_xfer_s   = query_seq_block_valid_in && query_seq_block_rdy_out;

   // First idle engine at or after rr_ptr; walking offsets downward lets the smallest offset win.
   always_comb begin
      free_idx_s = '0;
      cand_s     = '0;
      for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
         cand_s = {1'b0, rr_ptr_q} + (ENG_IDX_W+1)'(k);
         if (cand_s >= (ENG_IDX_W+1)'(NUM_ENGINES)) begin
            cand_s = cand_s - (ENG_IDX_W+1)'(NUM_ENGINES);
         end else begin
            cand_s = cand_s;
         end
         if (!busy_q[cand_s[ENG_IDX_W-1:0]]) begin
            free_idx_s = cand_s[ENG_IDX_W-1:0];
         end else begin
            free_idx_s = free_idx_s;
         end
      end
   end

   // Handshake routing: only the selected engine sees valid, upstream rdy comes from it alone.
   always_comb begin
      eng_query_info_valid_out      = '0;
      eng_query_seq_block_valid_out = '0;
      query_info_rdy_out            = 1'b0;
      query_seq_block_rdy_out       = 1'b0;
      case (state_q)
         ST_INFO: begin
            eng_query_info_valid_out = query_info_valid_in ? sel_onehot_s : '0;
            query_info_rdy_out       = eng_query_info_rdy_in[sel_q];
         end
         ST_BLOCKS: begin
            eng_query_seq_block_valid_out = query_seq_block_valid_in ? sel_onehot_s : '0;
            query_seq_block_rdy_out       = eng_query_seq_block_rdy_in[sel_q];
         end
         default: begin
            query_info_rdy_out      = 1'b0;
            query_seq_block_rdy_out = 1'b0;
         end
      endcase
   end

   // Next-state logic; a busy set on info transfer overrides a same-cycle done pulse.
   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      rr_ptr_d       = rr_ptr_q;
      num_blocks_d   = num_blocks_q;
      block_cnt_d    = block_cnt_q;
      dispatch_cnt_d = dispatch_cnt_q;
      busy_d         = busy_q & ~eng_done_in;
      case (state_q)
         ST_IDLE: begin
            if (query_info_valid_in && !all_busy_s) begin
               sel_d        = free_idx_s;
               num_blocks_d = num_query_blocks_in;
               state_d      = ST_INFO;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_INFO: begin
            if (info_xfer_s) begin
               busy_d         = busy_d | sel_onehot_s;
               dispatch_cnt_d = dispatch_cnt_q + 32'd1;
               block_cnt_d    = 16'd0;
               if (sel_q == ENG_IDX_W'(NUM_ENGINES - 1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = sel_q + ENG_IDX_W'(1);
               end
               if (num_blocks_q != 16'd0) begin
                  state_d = ST_BLOCKS;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_INFO;
            end
         end
         ST_BLOCKS: begin
            if (blk_xfer_s) begin
               block_cnt_d = block_cnt_q + 16'd1;
               if (block_cnt_q == num_blocks_q - 16'd1) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BLOCKS;
               end
            end else begin
               state_d = ST_BLOCKS;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         sel_q          <= '0;
         rr_ptr_q       <= '0;
         num_blocks_q   <= 16'd0;
         block_cnt_q    <= 16'd0;
         busy_q         <= '0;
         dispatch_cnt_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         rr_ptr_q       <= rr_ptr_d;
         num_blocks_q   <= num_blocks_d;
         block_cnt_q    <= block_cnt_d;
         busy_q         <= busy_d;
         dispatch_cnt_q <= dispatch_cnt_d;
      end
   end

endmodule
